// File: rtl/prog_counter.sv
// prog_counter: programmable-modulus up/down counter with parallel load, wrap/saturate, tc/co and sticky ovf.
// Defining PROG_COUNTER_PRESCALE_EN adds parameter P, a cnt prescaler and the pre_tc output.
module prog_counter #(
  parameter int N    = 8,
  parameter int INIT = 0
`ifdef PROG_COUNTER_PRESCALE_EN
  , parameter int P  = 4
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] din,
  input  logic         cnt,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] limit,
  output logic [N-1:0] pout,
  output logic         co,
  output logic         tc,
  output logic         ovf
`ifdef PROG_COUNTER_PRESCALE_EN
  , output logic       pre_tc
`endif
);

  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] INIT_VAL = N'(INIT);

  logic [N-1:0] r_pout;
  logic         r_ovf;
  logic [N-1:0] w_pout_next;
  logic         w_ovf_next;
  logic         w_tc;
  logic         w_step;

  // Boundary is direction dependent; >= so a loaded value above limit still wraps when counting up.
  assign w_tc = up ? (r_pout >= limit) : (r_pout == '0);

`ifdef PROG_COUNTER_PRESCALE_EN
  localparam int             PW   = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] PMAX = PW'(P - 1);

  logic [PW-1:0] r_pre;
  logic          w_pre_tc;

  assign w_pre_tc = (r_pre == PMAX);
  assign pre_tc   = cnt & w_pre_tc;
  assign w_step   = cnt & w_pre_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (clr || ld) begin
      r_pre <= '0;
    end else if (cnt) begin
      r_pre <= w_pre_tc ? '0 : r_pre + PW'(1);
    end
  end
`else
  assign w_step = cnt;
`endif

  assign co = w_step & w_tc & ~clr & ~ld;

  always_comb begin
    w_pout_next = r_pout;
    w_ovf_next  = r_ovf;
    if (clr) begin
      w_pout_next = INIT_VAL;
      w_ovf_next  = 1'b0;
    end else if (ld) begin
      w_pout_next = din;
    end else if (w_step) begin
      if (!w_tc) begin
        w_pout_next = up ? r_pout + ONE : r_pout - ONE;
      end else if (!sat) begin
        w_pout_next = up ? '0 : limit;
        w_ovf_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pout <= INIT_VAL;
      r_ovf  <= 1'b0;
    end else begin
      r_pout <= w_pout_next;
      r_ovf  <= w_ovf_next;
    end
  end

  assign pout = r_pout;
  assign tc   = w_tc;
  assign ovf  = r_ovf;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised successor to the team's basic n-bit up counter. Adds:
- programmable modulus (limit)
- up/down direction
- parallel load
- wrap or saturate mode
- terminal-count and sticky overflow flags

Used as the loop/index counter inside datapath controllers. Carry output chains instances for wider or nested loops.

Parameters:
N, 8, counter width in bits (N >= 2)
INIT, 0, value of pout after reset or clear; must satisfy INIT < 2^N

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear to INIT
ld  input  1  synchronous parallel load of din
din  input  N  load value
cnt  input  1  count enable (one step per enabled cycle)
up  input  1  1 = count up, 0 = count down
sat  input  1  1 = saturate at boundary, 0 = wrap
limit  input  N  terminal value (inclusive upper bound of count range)
pout  output  N  registered count value
co  output  1  combinational carry/borrow: step at boundary this cycle
tc  output  1  combinational: pout at boundary for the current direction
ovf  output  1  registered sticky flag: a wrap occurred

Behaviour:
- Reset (async, rst=1): pout=INIT, ovf=0 immediately, regardless of clk. Held while rst=1.
- Synchronous priority, highest first: clr > ld > cnt. With none active, pout holds.
- clr: pout<=INIT, ovf<=0.
- ld: pout<=din, ovf unchanged. A din above limit is legal.
- Boundary definition (tc):
  - up=1: tc = (pout >= limit).
  - up=0: tc = (pout == 0).
- Counting (cnt=1, no clr/ld):
  - up=1, tc=0: pout<=pout+1.
  - up=1, tc=1, sat=0: pout<=0 (wrap), ovf<=1.
  - up=1, tc=1, sat=1: pout holds.
  - up=0, tc=0: pout<=pout-1.
  - up=0, tc=1, sat=0: pout<=limit (wrap), ovf<=1.
  - up=0, tc=1, sat=1: pout holds at 0.
- co = cnt & tc & ~clr & ~ld. Asserted in saturate mode too, every cycle the counter is held at the boundary with cnt=1.
- Arithmetic is modulo 2^N. pout never exceeds limit through counting, only through ld.
- Boundary cases:
  - limit=0, up: pout stays 0; co=cnt every cycle; ovf sets on first cnt in wrap mode.
  - limit=2^N-1: full-range counter; co on all-ones, matching the basic counter.
  - Down from a loaded value above limit: decrements normally to 0, then wraps to limit.
- Direction, sat and limit may change any cycle. They take effect on the same edge; no pipelining.
- Latency: pout updates one clk edge after the enabling cycle. co and tc are same-cycle combinational.

Optional Feature:
PROG_COUNTER_PRESCALE_EN
- Defined:
  - Adds parameter P (default 4, P >= 1) and an internal ceil(log2 P)-bit prescaler.
  - pout steps only on every P-th cycle with cnt=1; co/tc gating uses the prescaler terminal.
  - co = cnt & tc & prescaler==P-1.
  - Prescaler is reset by rst, clr and ld, and is held when cnt=0.
  - Adds output pre_tc (1 bit): prescaler at P-1 and cnt=1.
- Not defined: no prescaler, no P, no pre_tc; every cnt cycle steps pout.

Test Plan:
1. Reset: assert rst mid-count with pout=5, between clock edges -> pout=INIT=0 and ovf=0 before the next edge. Release, then cnt=0 for 3 cycles -> pout stays 0.
2. Wrap up: N=4, limit=9, up=1, sat=0, cnt=1 for 12 cycles from 0 -> pout 0..9,0,1; co=1 only in the cycle pout=9; ovf=1 from the wrap onward. clr -> pout=0, ovf=0.
3. Saturate down: ld din=3, up=0, sat=1, cnt=1 for 6 cycles -> pout 3,2,1,0,0,0; co=1 in each cycle pout=0; ovf stays 0.
4. Priority: clr=1, ld=1 (din=7), cnt=1 in one cycle -> pout=INIT. Next cycle, ld=1 (din=7), cnt=1 -> pout=7, no increment.
5. Load above limit: limit=4, ld din=12, up=1, sat=0, cnt=1 -> tc=1, co=1, pout wraps to 0 next edge. Same setup with up=0 -> pout 12,11,...,0, then 4.
6. PROG_COUNTER_PRESCALE_EN with P=3: cnt=1 for 9 cycles from 0, limit=15 -> pout steps to 1,2,3 on cycles 3,6,9; pre_tc pulses on cycles 3,6,9. Dropping cnt for 2 cycles mid-period holds the prescaler.
